vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameters (name, default, meaning): N, 32, colour input width; PIX_DIV, 4, system clocks per pixel; H_ACTIVE, 640, visible pixels per line; H_FP, 16, horizontal front porch; H_SYNC, 96, hsync width; H_BP, 48, horizontal back porch; V_ACTIVE, 480, visible lines; V_FP, 10, vertical front porch; V_SYNC, 2, vsync lines; V_BP, 33, vertical back porch.
REQ-002 clock  input  1  single system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low (asserted at 0); deassertion synchronous to clock.
REQ-004 red  input  N  colour register value, bits [3:0] used.
REQ-005 green  input  N  colour register value, bits [3:0] used.
REQ-006 blue  input  N  colour register value, bits [3:0] used.
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 vga_r, vga_g, vga_b  output  4 each  pixel colour.
REQ-010 hcount, vcount  output  10 each  current pixel column/line.
REQ-011 active  output  1  high while (hcount, vcount) is inside the visible area.
REQ-012 frame_pulse  output  1  one-clock pulse at start of vertical blank.
REQ-013 frame_count  output  N  completed-frame counter.

Function
REQ-014 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-015 Divider counts 0..PIX_DIV-1 every clock, wraps to 0; pixel tick = divider at PIX_DIV-1 (one clock wide).
REQ-016 On tick: hcount increments; at H_TOTAL-1 wraps to 0 and vcount increments; vcount at V_TOTAL-1 with hcount wrap wraps to 0.
REQ-017 Counters hold between ticks; no other event alters them.
REQ-018 hsync, vsync, active, vga_* are registered; each reflects the counter values of the previous clock (1-clock latency after a counter change).
REQ-019 hsync = 0 iff hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656,751]); else 1.
REQ-020 vsync = 0 iff vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] ([490,491]); else 1.
REQ-021 active = 1 iff hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-022 Shadow colour registers (4 bits each) load red[3:0], green[3:0], blue[3:0] on the tick that moves counters to hcount=0, vcount=V_ACTIVE; otherwise hold (no mid-frame tearing).
REQ-023 vga_r/g/b = shadow values when active, else 4'h0.
REQ-024 frame_pulse = 1 for exactly the clock following the shadow-load tick; 0 otherwise.
REQ-025 frame_count increments by 1 on the same event, wraps modulo 2^N.
REQ-026 Input changes between shadow loads have no effect on outputs.
REQ-027 Upper bits [N-1:4] of colour inputs are ignored.

Reset
REQ-028 While reset = 0: divider, hcount, vcount, shadows, frame_count = 0; hsync = 1, vsync = 1, active = 0, vga_* = 0, frame_pulse = 0, all asynchronously.
REQ-029 Reset asserted mid-line or mid-frame: immediate return to REQ-028 values; after release timing restarts at (0,0) with divider 0.
REQ-030 After release, first tick occurs on the PIX_DIV-th rising edge; visible colour is 0 until the first shadow load.

Verification
REQ-031 Release reset -> hcount 0->1 after 4 clocks; hsync low for exactly 96*4 = 384 clocks starting 656*4 (+1 latency) clocks after release.
REQ-032 Run full frame -> line period 3200 clocks, frame period 1 680 000 clocks, vsync low for 2 lines (6400 clocks).
REQ-033 red=0xF, green=0x3, blue=0xA set before first vblank -> frame_pulse once, then in frame 2 active pixels show F/3/A, blanking shows 0.
REQ-034 Change red to 0x5 at vcount=100 -> vga_r stays old value for rest of frame, shows 0x5 after next frame_pulse.
REQ-035 Assert reset at hcount=300, vcount=200 -> outputs at reset values immediately, frame_count=0, timing restarts from (0,0).
REQ-036 Preload frame_count near 2^N-1 (force) -> next frame_pulse wraps it to 0; red=0xFFFFFFF0 -> vga_r = 0.

Source files
------------

// File: rtl/vga_scanout.sv
// VGA raster timing generator with frame-synchronous colour shadowing.
// Counters advance once per pixel tick; all video outputs are registered.
module vga_scanout #(
  parameter int N        = 32,
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] red,
  input  logic [N-1:0] green,
  input  logic [N-1:0] blue,
  output logic         hsync,
  output logic         vsync,
  output logic [3:0]   vga_r,
  output logic [3:0]   vga_g,
  output logic [3:0]   vga_b,
  output logic [9:0]   hcount,
  output logic [9:0]   vcount,
  output logic         active,
  output logic         frame_pulse,
  output logic [N-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_LO    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [3:0]    sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
  logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hs_q, hs_d, vs_q, vs_d, act_q, act_d;
  logic          fp_q, fp_d;
  logic [N-1:0]  fc_q, fc_d;
  logic          tick, h_wrap, load, vis;
  logic          unused_hi;

  assign unused_hi = ^{red[N-1:4], green[N-1:4], blue[N-1:4]};

  always_comb begin
    tick   = (div_q == DIV_LAST);
    h_wrap = (h_q == H_LAST);
    div_d  = tick ? '0 : div_q + DW'(1);
    h_d    = h_q;
    v_d    = v_q;
    if (tick) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Shadows load on the tick entering (0, V_ACTIVE): first blank line.
    load   = tick && h_wrap && (v_q == V_VIS_LAST);
    vis    = (h_q < H_VIS) && (v_q < V_VIS);
    hs_d   = !((h_q >= HS_LO) && (h_q <= HS_HI));
    vs_d   = !((v_q >= VS_LO) && (v_q <= VS_HI));
    act_d  = vis;
    r_d    = vis ? sh_r_q : 4'h0;
    g_d    = vis ? sh_g_q : 4'h0;
    b_d    = vis ? sh_b_q : 4'h0;
    sh_r_d = load ? red[3:0]   : sh_r_q;
    sh_g_d = load ? green[3:0] : sh_g_q;
    sh_b_d = load ? blue[3:0]  : sh_b_q;
    fp_d   = load;
    fc_d   = load ? fc_q + N'(1) : fc_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      sh_r_q <= '0;
      sh_g_q <= '0;
      sh_b_q <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      act_q  <= 1'b0;
      fp_q   <= 1'b0;
      fc_q   <= '0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      sh_r_q <= sh_r_d;
      sh_g_q <= sh_g_d;
      sh_b_q <= sh_b_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      act_q  <= act_d;
      fp_q   <= fp_d;
      fc_q   <= fc_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign active      = act_q;
  assign frame_pulse = fp_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster.
// Expected outputs derive from the clock count since reset release.
module tb_vga_scanout;

  localparam int N   = 5;
  localparam int PD  = 2;
  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 2;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FR  = HT * VT * PD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] red = '0, green = '0, blue = '0;
  logic         hsync, vsync, active, frame_pulse;
  logic [3:0]   vga_r, vga_g, vga_b;
  logic [9:0]   hcount, vcount;
  logic [N-1:0] frame_count;

  vga_scanout #(
    .N(N), .PIX_DIV(PD),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clock(clk), .reset(rst_n),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hcount(hcount), .vcount(vcount),
    .active(active), .frame_pulse(frame_pulse),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]   h, v;
    logic         hs, vs, act, fp;
    logic [3:0]   r, g, b;
    logic [N-1:0] fc;
  } exp_t;

  exp_t         sb[$];
  int           k;
  logic [3:0]   sh_r, sh_g, sh_b;
  logic [N-1:0] fc_m;
  int           errors = 0;
  int           checks = 0;

  function automatic int hpos(int kk);
    return (kk / PD) % HT;
  endfunction

  function automatic int vpos(int kk);
    return ((kk / PD) / HT) % VT;
  endfunction

  task automatic model_reset();
    k = 0; sh_r = '0; sh_g = '0; sh_b = '0; fc_m = '0;
  endtask

  task automatic drive_cycle();
    exp_t e;
    logic [3:0] ir, ig, ib;
    int ph, pv;
    bit pact, ld;
    ir = red[3:0]; ig = green[3:0]; ib = blue[3:0];
    @(posedge clk);
    k++;
    ph   = hpos(k - 1);
    pv   = vpos(k - 1);
    pact = (ph < HA) && (pv < VA);
    e.h   = 10'(hpos(k));
    e.v   = 10'(vpos(k));
    e.hs  = !((ph >= HA + HFP) && (ph < HA + HFP + HS));
    e.vs  = !((pv >= VA + VFP) && (pv < VA + VFP + VS));
    e.act = pact;
    e.r   = pact ? sh_r : 4'h0;
    e.g   = pact ? sh_g : 4'h0;
    e.b   = pact ? sh_b : 4'h0;
    ld = (k % PD == 0) && (hpos(k) == 0) && (vpos(k) == VA);
    e.fp = ld;
    if (ld) begin
      sh_r = ir; sh_g = ig; sh_b = ib;
      fc_m = fc_m + 1'b1;
    end
    e.fc = fc_m;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    red = 5'h1F; green = 5'h03; blue = 5'h0A;
    repeat (3) @(negedge clk);
    checks++;
    if ({hsync, vsync, active, frame_pulse} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_ctl got %b want 1100",
               {hsync, vsync, active, frame_pulse});
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b});
    end
    checks++;
    if ({hcount, vcount} !== 20'h0 || frame_count !== '0) begin
      errors++;
      $display("FAIL reset_cnt got h=%0d v=%0d fc=%0d want 0",
               hcount, vcount, frame_count);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_timing();
    exp_t e;
    int hs_run = 0, vs_run = 0, first_hs = -1;
    for (int i = 0; i < 2 * FR; i++) begin
      drive_cycle();
      e = sb.pop_front();
      checks++;
      if (hcount !== e.h || vcount !== e.v) begin
        errors++;
        $display("FAIL counters k=%0d got %0d,%0d want %0d,%0d",
                 k, hcount, vcount, e.h, e.v);
      end
      checks++;
      if ({hsync, vsync, active} !== {e.hs, e.vs, e.act}) begin
        errors++;
        $display("FAIL syncs k=%0d got %b want %b", k,
                 {hsync, vsync, active}, {e.hs, e.vs, e.act});
      end
      if (hsync === 1'b0) begin
        if (first_hs < 0) first_hs = k;
        hs_run++;
      end else if (hs_run != 0) begin
        checks++;
        if (hs_run != HS * PD) begin
          errors++;
          $display("FAIL hsync_width got %0d want %0d", hs_run, HS * PD);
        end
        hs_run = 0;
      end
      if (vsync === 1'b0) vs_run++;
      else if (vs_run != 0) begin
        checks++;
        if (vs_run != VS * HT * PD) begin
          errors++;
          $display("FAIL vsync_width got %0d want %0d",
                   vs_run, VS * HT * PD);
        end
        vs_run = 0;
      end
    end
    checks++;
    if (first_hs != (HA + HFP) * PD + 1) begin
      errors++;
      $display("FAIL hsync_start got %0d want %0d",
               first_hs, (HA + HFP) * PD + 1);
    end
  endtask

  task automatic test_colour();
    exp_t e;
    int pulses = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      if (hpos(k) == 0 && vpos(k) == 2 && i < FR) red = 5'h05;
      drive_cycle();
      e = sb.pop_front();
      if (frame_pulse === 1'b1) pulses++;
      checks++;
      if ({vga_r, vga_g, vga_b} !== {e.r, e.g, e.b}) begin
        errors++;
        $display("FAIL colour k=%0d got %h want %h", k,
                 {vga_r, vga_g, vga_b}, {e.r, e.g, e.b});
      end
      checks++;
      if (frame_pulse !== e.fp || frame_count !== e.fc) begin
        errors++;
        $display("FAIL frame k=%0d got fp=%b fc=%0d want fp=%b fc=%0d",
                 k, frame_pulse, frame_count, e.fp, e.fc);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL pulse_count got %0d want 2", pulses);
    end
  endtask

  task automatic test_frame_wrap();
    exp_t e;
    bit saw_wrap = 0;
    red = 5'h10;
    for (int i = 0; i < 30 * FR; i++) begin
      drive_cycle();
      e = sb.pop_front();
      if (frame_pulse === 1'b1 && frame_count === '0) saw_wrap = 1;
      checks++;
      if (frame_pulse !== e.fp || frame_count !== e.fc) begin
        errors++;
        $display("FAIL wrap k=%0d got fp=%b fc=%0d want fp=%b fc=%0d",
                 k, frame_pulse, frame_count, e.fp, e.fc);
      end
      checks++;
      if (vga_r !== e.r) begin
        errors++;
        $display("FAIL upper_bits k=%0d got %h want %h", k, vga_r, e.r);
      end
    end
    checks++;
    if (!saw_wrap) begin
      errors++;
      $display("FAIL frame_wrap got no wrap want wrap to 0");
    end
  endtask

  task automatic test_midreset();
    exp_t e;
    int n = 0;
    while (!(hpos(k) == 5 && vpos(k) == 3) && n < FR) begin
      drive_cycle();
      e = sb.pop_front();
      n++;
    end
    checks++;
    if (hcount !== 10'd5 || vcount !== 10'd3) begin
      errors++;
      $display("FAIL pre_reset got %0d,%0d want 5,3", hcount, vcount);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hsync, vsync, active, frame_pulse, vga_r, vga_g, vga_b}
        !== {4'b1100, 12'h000} || {hcount, vcount} !== 20'h0
        || frame_count !== '0) begin
      errors++;
      $display("FAIL async_reset got h=%0d v=%0d fc=%0d ctl=%b rgb=%h",
               hcount, vcount, frame_count,
               {hsync, vsync, active, frame_pulse}, {vga_r, vga_g, vga_b});
    end
    red = 5'h0C; green = 5'h07; blue = 5'h01;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < FR + 40; i++) begin
      drive_cycle();
      e = sb.pop_front();
      checks++;
      if (hcount !== e.h || vcount !== e.v || frame_count !== e.fc
          || {vga_r, vga_g, vga_b} !== {e.r, e.g, e.b}) begin
        errors++;
        $display("FAIL restart k=%0d got %0d,%0d fc=%0d rgb=%h want %0d,%0d fc=%0d rgb=%h",
                 k, hcount, vcount, frame_count, {vga_r, vga_g, vga_b},
                 e.h, e.v, e.fc, {e.r, e.g, e.b});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timing();
    test_colour();
    test_frame_wrap();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
